// File: rtl/column_ram_bist_if.sv
// -----------------------------------------------------------------------------
// column_ram_bist_if
// Write/read bus between the BIST engine and the column message RAM.
//   ram_din  : write data, channel c at [c*QUAN_SIZE +: QUAN_SIZE]
//   ram_addr : word address
//   ram_we   : write enable
//   ram_dout : read data, same packing as ram_din
// master = BIST engine side, slave = RAM side.
// -----------------------------------------------------------------------------
interface column_ram_bist_if #(
    parameter int unsigned QUAN_SIZE         = 4,
    parameter int unsigned CHECK_PARALLELISM = 85,
    parameter int unsigned DEPTH             = 1024,
    parameter int unsigned ADDR              = $clog2(DEPTH)
) ();
    logic [CHECK_PARALLELISM*QUAN_SIZE-1:0] ram_din;
    logic [ADDR-1:0]                        ram_addr;
    logic                                   ram_we;
    logic [CHECK_PARALLELISM*QUAN_SIZE-1:0] ram_dout;

    modport master (
        output ram_din,
        output ram_addr,
        output ram_we,
        input  ram_dout
    );

    modport slave (
        input  ram_din,
        input  ram_addr,
        input  ram_we,
        output ram_dout
    );
endinterface

// File: rtl/column_ram_bist.sv
// -----------------------------------------------------------------------------
// column_ram_bist
// Built-in self-test for the column message RAM: writes every address with a
// selectable pattern, reads everything back and compares every channel.
// Ports:
//   sys_clk, rstn      : clock, asynchronous active-low reset
//   start              : run request, accepted in IDLE only
//   pattern_sel        : 0 zeros, 1 ones, 2 checkerboard, 3 (addr+channel)
//   err_inject         : (only with COLUMN_RAM_BIST_ERR_INJECT_EN) flip bit 0 of
//                        channel 0 in the word written at address 0
//   ram                : RAM bus (column_ram_bist_if.master)
//   busy, done         : run in progress / one-cycle completion pulse
//   pass, err_cnt      : result of the last run, number of bad words
//   first_err_addr/mask: first failing address and its per-channel mismatch
// Optional feature macro: COLUMN_RAM_BIST_ERR_INJECT_EN
// -----------------------------------------------------------------------------
module column_ram_bist #(
    parameter int unsigned QUAN_SIZE         = 4,
    parameter int unsigned CHECK_PARALLELISM = 85,
    parameter int unsigned DEPTH             = 1024,
    parameter int unsigned ADDR              = $clog2(DEPTH),
    parameter int unsigned RD_LATENCY        = 1
) (
    input  logic                         sys_clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [1:0]                   pattern_sel,
`ifdef COLUMN_RAM_BIST_ERR_INJECT_EN
    input  logic                         err_inject,
`endif
    column_ram_bist_if.master            ram,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [ADDR:0]                err_cnt,
    output logic [ADDR-1:0]              first_err_addr,
    output logic [CHECK_PARALLELISM-1:0] first_err_mask
);
    localparam int unsigned W  = CHECK_PARALLELISM * QUAN_SIZE;
    localparam int unsigned DW = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e                         state_q;
    logic [1:0]                     pat_q;
    logic [DW-1:0]                  drain_q;
    logic [ADDR-1:0]                addr_inc;

    // Expected word, its address and a valid bit, delayed to line up with ram_dout.
    logic [RD_LATENCY-1:0]          pv_q;
    logic [W-1:0]                   pe_q [RD_LATENCY];
    logic [ADDR-1:0]                pa_q [RD_LATENCY];

    logic [CHECK_PARALLELISM-1:0]   chan_mis;
    logic                           word_mis;
    logic [ADDR:0]                  err_cnt_nxt;

    function automatic logic [W-1:0] pattern(input logic [ADDR-1:0] a, input logic [1:0] sel);
        logic [W-1:0]         w;
        logic [QUAN_SIZE-1:0] alt;
        logic [31:0]          sum;
        w = '0;
        // 1010... alternation: odd bit positions set
        for (int i = 0; i < int'(QUAN_SIZE); i++) begin
            alt[i] = (i % 2 == 1);
        end
        for (int c = 0; c < int'(CHECK_PARALLELISM); c++) begin
            sum = 32'(a) + 32'(c);
            case (sel)
                2'd0:    w[c*QUAN_SIZE +: QUAN_SIZE] = '0;
                2'd1:    w[c*QUAN_SIZE +: QUAN_SIZE] = '1;
                2'd2:    w[c*QUAN_SIZE +: QUAN_SIZE] = (a[0] ^ (c % 2 == 1)) ? ~alt : alt;
                default: w[c*QUAN_SIZE +: QUAN_SIZE] = sum[QUAN_SIZE-1:0];
            endcase
        end
        return w;
    endfunction

    assign addr_inc = ram.ram_addr + 1'b1;

    always_comb begin
        chan_mis = '0;
        for (int c = 0; c < int'(CHECK_PARALLELISM); c++) begin
            chan_mis[c] = ram.ram_dout[c*QUAN_SIZE +: QUAN_SIZE]
                          != pe_q[RD_LATENCY-1][c*QUAN_SIZE +: QUAN_SIZE];
        end
        word_mis    = pv_q[RD_LATENCY-1] && (|chan_mis);
        err_cnt_nxt = err_cnt;
        if (word_mis && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= StIdle;
            pat_q          <= '0;
            drain_q        <= '0;
            ram.ram_din    <= '0;
            ram.ram_addr   <= '0;
            ram.ram_we     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_mask <= '0;
            pv_q           <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pe_q[i] <= '0;
                pa_q[i] <= '0;
            end
        end else begin
            // The address on the bus now returns data RD_LATENCY cycles later.
            pv_q[0] <= (state_q == StRead);
            pe_q[0] <= pattern(ram.ram_addr, pat_q);
            pa_q[0] <= ram.ram_addr;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end

            err_cnt <= err_cnt_nxt;
            // err_cnt never returns to zero within a run, so zero means "no error yet".
            if (word_mis && (err_cnt == '0)) begin
                first_err_addr <= pa_q[RD_LATENCY-1];
                first_err_mask <= chan_mis;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q        <= StWrite;
                        pat_q          <= pattern_sel;
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        first_err_mask <= '0;
                        ram.ram_addr   <= '0;
                        ram.ram_we     <= 1'b1;
                        // Address 0 is loaded on this edge, so this is the only
                        // point where the injection request matters.
`ifdef COLUMN_RAM_BIST_ERR_INJECT_EN
                        ram.ram_din    <= pattern('0, pattern_sel) ^ W'(err_inject);
`else
                        ram.ram_din    <= pattern('0, pattern_sel);
`endif
                    end
                end
                StWrite: begin
                    if (ram.ram_addr == ADDR'(DEPTH - 1)) begin
                        state_q      <= StRead;
                        ram.ram_addr <= '0;
                        ram.ram_we   <= 1'b0;
                        ram.ram_din  <= '0;
                    end else begin
                        ram.ram_addr <= addr_inc;
                        ram.ram_din  <= pattern(addr_inc, pat_q);
                    end
                end
                StRead: begin
                    if (ram.ram_addr == ADDR'(DEPTH - 1)) begin
                        state_q      <= StDrain;
                        ram.ram_addr <= '0;
                        drain_q      <= '0;
                    end else begin
                        ram.ram_addr <= addr_inc;
                    end
                end
                StDrain: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == DW'(RD_LATENCY - 1)) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        // Last compare lands on this edge; use the updated count.
                        pass    <= (err_cnt_nxt == '0);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_column_ram_bist.sv
module tb_column_ram_bist;
    localparam int unsigned QS    = 4;
    localparam int unsigned CP    = 85;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned W     = CP * QS;

    logic          sys_clk = 1'b0;
    logic          rstn;
    logic          start1, start2;
    logic [1:0]    pattern_sel;
    logic          err_inject;
    logic [15:0]   fault_mask;
    int            fault_ch;
    int            cur = 1;
    int            n_checks = 0;
    int            n_fail = 0;

    logic          busy1, done1, pass1, busy2, done2, pass2;
    logic [AW:0]   err_cnt1, err_cnt2;
    logic [AW-1:0] fea1, fea2;
    logic [CP-1:0] fem1, fem2;

    column_ram_bist_if #(.QUAN_SIZE(QS), .CHECK_PARALLELISM(CP), .DEPTH(DEPTH)) ram1 ();
    column_ram_bist_if #(.QUAN_SIZE(QS), .CHECK_PARALLELISM(CP), .DEPTH(DEPTH)) ram2 ();

    column_ram_bist #(
        .QUAN_SIZE(QS), .CHECK_PARALLELISM(CP), .DEPTH(DEPTH), .RD_LATENCY(1)
    ) u_dut1 (
        .sys_clk(sys_clk), .rstn(rstn), .start(start1), .pattern_sel(pattern_sel),
`ifdef COLUMN_RAM_BIST_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .ram(ram1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
        .first_err_addr(fea1), .first_err_mask(fem1)
    );

    column_ram_bist #(
        .QUAN_SIZE(QS), .CHECK_PARALLELISM(CP), .DEPTH(DEPTH), .RD_LATENCY(2)
    ) u_dut2 (
        .sys_clk(sys_clk), .rstn(rstn), .start(start2), .pattern_sel(pattern_sel),
`ifdef COLUMN_RAM_BIST_ERR_INJECT_EN
        .err_inject(1'b0),
`endif
        .ram(ram2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err_addr(fea2), .first_err_mask(fem2)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural RAMs; stuck-at-0 fault on channel fault_ch at addresses in fault_mask.
    logic [W-1:0] mem1 [DEPTH];
    logic [W-1:0] mem2 [DEPTH];
    logic [W-1:0] rd1, rd2a, rd2b;

    function automatic logic [W-1:0] faulted(input logic [W-1:0] d, input logic [AW-1:0] a);
        logic [W-1:0] r;
        r = d;
        if (fault_mask[a]) r[fault_ch*QS +: QS] = '0;
        return r;
    endfunction

    always @(posedge sys_clk) begin
        if (ram1.ram_we) mem1[ram1.ram_addr] <= ram1.ram_din;
        rd1 <= faulted(mem1[ram1.ram_addr], ram1.ram_addr);
        if (ram2.ram_we) mem2[ram2.ram_addr] <= ram2.ram_din;
        rd2a <= faulted(mem2[ram2.ram_addr], ram2.ram_addr);
        rd2b <= rd2a;
    end
    assign ram1.ram_dout = rd1;
    assign ram2.ram_dout = rd2b;

    // Views of whichever DUT the current run targets.
    logic [W-1:0]  d_din;
    logic [AW-1:0] d_addr, d_fea;
    logic          d_we, d_busy, d_done, d_pass;
    logic [AW:0]   d_cnt;
    logic [CP-1:0] d_fem;
    always_comb begin
        d_din  = (cur == 2) ? ram2.ram_din  : ram1.ram_din;
        d_addr = (cur == 2) ? ram2.ram_addr : ram1.ram_addr;
        d_we   = (cur == 2) ? ram2.ram_we   : ram1.ram_we;
        d_busy = (cur == 2) ? busy2    : busy1;
        d_done = (cur == 2) ? done2    : done1;
        d_pass = (cur == 2) ? pass2    : pass1;
        d_cnt  = (cur == 2) ? err_cnt2 : err_cnt1;
        d_fea  = (cur == 2) ? fea2     : fea1;
        d_fem  = (cur == 2) ? fem2     : fem1;
    end

    function automatic logic [W-1:0] tb_pat(input logic [1:0] sel, input int a);
        logic [W-1:0] w;
        w = '0;
        for (int c = 0; c < int'(CP); c++) begin
            case (sel)
                2'd0:    w[c*QS +: QS] = 4'h0;
                2'd1:    w[c*QS +: QS] = 4'hF;
                2'd2:    w[c*QS +: QS] = (((a ^ c) & 1) == 1) ? 4'h5 : 4'hA;
                default: w[c*QS +: QS] = 4'((a + c) & 15);
            endcase
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ram_we"},   d_we,   0);
        check({tag, " ram_addr"}, d_addr, 0);
        check({tag, " ram_din"},  d_din,  0);
        check({tag, " busy"},     d_busy, 0);
        check({tag, " done"},     d_done, 0);
        check({tag, " pass"},     d_pass, 0);
        check({tag, " err_cnt"},  d_cnt,  0);
        check({tag, " fea"},      d_fea,  0);
        check({tag, " fem"},      d_fem,  0);
    endtask

    // k counts cycles after the start edge: cycle N+k is seen at the k-th negedge.
    task automatic run_bist(input int which, input logic [1:0] pat, input logic inj,
                            input int pulse_at, input int rst_at, input int exp_lat,
                            input int exp_cnt, input int exp_addr, input logic [CP-1:0] exp_mask);
        int           k;
        logic         seen;
        logic [W-1:0] w0;
        cur = which;
        @(negedge sys_clk);
        pattern_sel = pat;
        err_inject  = inj;
        if (which == 2) start2 = 1'b1; else start1 = 1'b1;
        @(negedge sys_clk);
        start1 = 1'b0;
        start2 = 1'b0;
        k      = 1;
        seen   = 1'b0;
        while (!seen && k <= 100) begin
            if (k == 1) begin
                w0 = tb_pat(pat, 0);
                w0[0] = w0[0] ^ inj;
                check("busy after start", d_busy, 1);
                check("write addr0 we", d_we, 1);
                check("write addr0 data", d_din, w0);
            end
            if (k == 6) begin
                check("write addr5 addr", d_addr, 5);
                check("write addr5 data", d_din, tb_pat(pat, 5));
            end
            if (k == int'(DEPTH) + 4) begin
                check("read addr3 we", d_we, 0);
                check("read addr3 addr", d_addr, 3);
            end
            if (k == pulse_at)     start1 = 1'b1;
            if (k == pulse_at + 1) start1 = 1'b0;
            if (k == rst_at) begin
                check("pre-reset addr", d_addr, rst_at - int'(DEPTH) - 1);
                check("pre-reset err_cnt", d_cnt, exp_cnt);
                check("pre-reset fea", d_fea, exp_addr);
                rstn = 1'b0;
                #1;
                check_all_zero("async reset");
                @(negedge sys_clk);
                rstn = 1'b1;
                return;
            end
            if (d_done) seen = 1'b1;
            else begin
                @(negedge sys_clk);
                k++;
            end
        end
        check("done latency", seen ? k : 0, exp_lat);
        check("pass", d_pass, (exp_cnt == 0));
        check("err_cnt", d_cnt, exp_cnt);
        check("first_err_addr", d_fea, exp_addr);
        check("first_err_mask", d_fem, exp_mask);
        @(negedge sys_clk);
        check("done one cycle", d_done, 0);
        check("busy cleared", d_busy, 0);
        check("pass held", d_pass, (exp_cnt == 0));
    endtask

    logic [CP-1:0] one;

    initial begin
        one         = {{(CP-1){1'b0}}, 1'b1};
        rstn        = 1'b0;
        start1      = 1'b0;
        start2      = 1'b0;
        pattern_sel = 2'd0;
        err_inject  = 1'b0;
        fault_mask  = '0;
        fault_ch    = 0;
        repeat (3) @(negedge sys_clk);
        cur = 1;
        check_all_zero("reset dut1");
        cur = 2;
        check_all_zero("reset dut2");
        rstn = 1'b1;

        // Good RAM, all zeros
        run_bist(1, 2'd0, 1'b0, 0, 0, 34, 0, 0, '0);
        // Channel 7 stuck at 0 at address 5, address+channel pattern expects 0xC
        fault_ch = 7; fault_mask = 16'h0020;
        run_bist(1, 2'd3, 1'b0, 0, 0, 34, 1, 5, one << 7);
        // Channel 3 stuck at addresses 2 and 9, all ones
        fault_ch = 3; fault_mask = 16'h0204;
        run_bist(1, 2'd1, 1'b0, 0, 0, 34, 2, 2, one << 3);
        // Start pulse in the middle of READ must be ignored
        fault_mask = '0;
        run_bist(1, 2'd2, 1'b0, 20, 0, 34, 0, 0, '0);
        // Reset while reading address 8, after one error already counted
        fault_ch = 3; fault_mask = 16'h0004;
        run_bist(1, 2'd1, 1'b0, 0, 25, 0, 1, 2, '0);
        fault_mask = '0;
        run_bist(1, 2'd0, 1'b0, 0, 0, 34, 0, 0, '0);
`ifdef COLUMN_RAM_BIST_ERR_INJECT_EN
        run_bist(1, 2'd1, 1'b1, 0, 0, 34, 1, 0, one);
`endif
        // Two-cycle read latency, checkerboard
        run_bist(2, 2'd2, 1'b0, 0, 0, 35, 0, 0, '0);
        run_bist(2, 2'd3, 1'b0, 0, 0, 35, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
